// File: rtl/mycpu_wb_load_queue.sv
// In-order writeback queue between MEM and the register file: pairs in-order SRAM load data with queued loads.
// Optional lwl/lwr merge enabled by defining MYCPU_WB_LWLR_EN.
module mycpu_wb_load_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RF_AW = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_mode,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_rt_cont,
    input  logic [RF_AW-1:0] in_dest,
    input  logic             rsp_valid,
    input  logic [31:0]      rsp_rdata,
    input  logic             flush,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [RF_AW-1:0] wb_dest,
    output logic [31:0]      wb_data,
    output logic             rsp_err
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [5:0]       mode;
        logic [31:0]      alu;
`ifdef MYCPU_WB_LWLR_EN
        logic [31:0]      rt;
`endif
        logic [RF_AW-1:0] dest;
    } entryT;

    entryT       queue [DEPTH];
    logic [31:0] dataFifo [DEPTH];
    logic [PW-1:0] head, tail, dHead, dTail;
    logic [CW-1:0] count, loadCnt, dCount, dropCnt;

    entryT       headEntry, newEntry;
    logic        headIsLoad, accept, retire, popData;
    logic        rspDrop, rspPush, rspBad;
    logic [CW-1:0] dropAfter, dCountAfter;
    logic [1:0]  a;
    logic [31:0] d;
    logic [7:0]  byteV;
    logic [15:0] halfV;
    logic        retWe;
    logic [31:0] retData;

    assign in_ready   = count < FULL;
    assign accept     = in_valid && in_ready && !flush;
    assign headEntry  = queue[head];
    assign headIsLoad = headEntry.mode[5];
    assign retire     = (count != '0) && !flush && (!headIsLoad || dCount != '0);
    assign popData    = retire && headIsLoad;

    // Responses owed to flushed loads are swallowed before any pairing is attempted.
    assign rspDrop     = rsp_valid && (dropCnt != '0);
    assign rspPush     = rsp_valid && (dropCnt == '0) && (loadCnt > dCount);
    assign rspBad      = rsp_valid && (dropCnt == '0) && !(loadCnt > dCount);
    assign dropAfter   = dropCnt - CW'(rspDrop);
    assign dCountAfter = dCount + CW'(rspPush);

    always_comb begin
        newEntry      = '0;
        newEntry.mode = in_mode;
        newEntry.alu  = in_alu_result;
        newEntry.dest = in_dest;
`ifdef MYCPU_WB_LWLR_EN
        newEntry.rt   = in_rt_cont;
`endif
    end

`ifndef MYCPU_WB_LWLR_EN
    logic unusedRt;
    assign unusedRt = ^in_rt_cont;
`endif

    assign a     = headEntry.alu[1:0];
    assign d     = dataFifo[dHead];
    assign byteV = d[{a, 3'b000} +: 8];
    assign halfV = d[{a[1], 4'b0000} +: 16];

    // Writeback value for the head entry, meaningful only when it retires.
    always_comb begin
        retWe   = 1'b0;
        retData = '0;
        if (!headIsLoad) begin
            retWe   = headEntry.mode[4];
            retData = headEntry.alu;
        end else begin
            case (headEntry.mode[3:1])
                3'b000: begin
                    retWe   = 1'b1;
                    retData = {{24{headEntry.mode[0] & byteV[7]}}, byteV};
                end
                3'b001: begin
                    retWe   = 1'b1;
                    retData = {{16{headEntry.mode[0] & halfV[15]}}, halfV};
                end
                3'b010: begin
                    retWe   = 1'b1;
                    retData = d;
                end
`ifdef MYCPU_WB_LWLR_EN
                3'b011: begin
                    retWe = 1'b1;
                    case (a)
                        2'd0: retData = {d[7:0],  headEntry.rt[23:0]};
                        2'd1: retData = {d[15:0], headEntry.rt[15:0]};
                        2'd2: retData = {d[23:0], headEntry.rt[7:0]};
                        2'd3: retData = d;
                    endcase
                end
                3'b100: begin
                    retWe = 1'b1;
                    case (a)
                        2'd0: retData = d;
                        2'd1: retData = {headEntry.rt[31:24], d[31:8]};
                        2'd2: retData = {headEntry.rt[31:16], d[31:16]};
                        2'd3: retData = {headEntry.rt[31:8],  d[31:24]};
                    endcase
                end
`endif
                default: begin
                    retWe   = 1'b0;
                    retData = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept)  queue[tail]     <= newEntry;
        if (rspPush) dataFifo[dTail] <= rsp_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            dHead    <= '0;
            dTail    <= '0;
            count    <= '0;
            loadCnt  <= '0;
            dCount   <= '0;
            dropCnt  <= '0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (rspBad) rsp_err <= 1'b1;
            wb_valid <= retire;
            if (retire) begin
                wb_we   <= retWe;
                wb_dest <= headEntry.dest;
                wb_data <= retData;
            end
            if (flush) begin
                head    <= '0;
                tail    <= '0;
                dHead   <= '0;
                dTail   <= '0;
                count   <= '0;
                loadCnt <= '0;
                dCount  <= '0;
                // Every queued load without data still has a response in flight.
                dropCnt <= dropAfter + (loadCnt - dCountAfter);
            end else begin
                if (accept)  tail  <= tail + PW'(1);
                if (retire)  head  <= head + PW'(1);
                if (rspPush) dTail <= dTail + PW'(1);
                if (popData) dHead <= dHead + PW'(1);
                count   <= count + CW'(accept) - CW'(retire);
                loadCnt <= loadCnt + CW'(accept && in_mode[5]) - CW'(popData);
                dCount  <= dCountAfter - CW'(popData);
                dropCnt <= dropAfter;
            end
        end
    end
endmodule

// File: tb/tb_mycpu_wb_load_queue.sv
// Scoreboard bench for mycpu_wb_load_queue; expectations pushed at stimulus, compared when writebacks appear.
module tb_mycpu_wb_load_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_mode;
    logic [31:0] in_alu_result;
    logic [31:0] in_rt_cont;
    logic [4:0]  in_dest;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        flush;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        rsp_err;

    localparam logic [5:0] M_ALU  = 6'b010000;
    localparam logic [5:0] M_LB   = 6'b100001;
    localparam logic [5:0] M_LBU  = 6'b100000;
    localparam logic [5:0] M_LH   = 6'b100011;
    localparam logic [5:0] M_LW   = 6'b100100;
    localparam logic [5:0] M_LWL  = 6'b100110;
    localparam logic [5:0] M_LWR  = 6'b101000;
    localparam logic [5:0] M_BAD  = 6'b101010;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
    } wbT;

    wbT obsQ[$];
    int obsCyc[$];
    wbT expQ[$];
    int cyc = 0;
    int nChecks = 0;
    int nErrors = 0;

    mycpu_wb_load_queue #(.DEPTH(4), .RF_AW(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_alu_result(in_alu_result), .in_rt_cont(in_rt_cont), .in_dest(in_dest),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .flush(flush),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wb_valid) begin
            obsQ.push_back({wb_we, wb_dest, wb_data});
            obsCyc.push_back(cyc);
        end
    endtask

    task automatic offer(input logic [5:0] m, input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] dst);
        in_valid = 1'b1; in_mode = m; in_alu_result = alu; in_rt_cont = rt; in_dest = dst;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd, output int rCyc);
        rCyc = cyc;
        rsp_valid = 1'b1; rsp_rdata = rd;
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_mode = '0; in_alu_result = '0; in_rt_cont = '0;
        in_dest = '0; rsp_valid = 1'b0; rsp_rdata = '0; flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
        nChecks++; if (wb_valid !== 1'b0) begin nErrors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        nChecks++; if (wb_we !== 1'b0) begin nErrors++; $display("FAIL reset_wb_we got %b want 0", wb_we); end
        nChecks++; if (wb_dest !== 5'd0) begin nErrors++; $display("FAIL reset_wb_dest got %h want 0", wb_dest); end
        nChecks++; if (wb_data !== 32'd0) begin nErrors++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
        nChecks++; if (rsp_err !== 1'b0) begin nErrors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        nChecks++; if (in_ready !== 1'b1) begin nErrors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        obsQ.delete(); obsCyc.delete();
    endtask

    task automatic test_nonload();
        int t;
        wbT o, e;
        t = cyc;
        expQ.push_back({1'b1, 5'd3, 32'h12345678});
        offer(M_ALU, 32'h12345678, 32'h0, 5'd3);
        tick();
        expQ.push_back({1'b0, 5'd4, 32'h0BADF00D});
        offer(6'b000000, 32'h0BADF00D, 32'h0, 5'd4);
        tick(); tick();
        nChecks++; if (obsQ.size() != 2) begin nErrors++; $display("FAIL nonload_count got %0d want 2", obsQ.size()); end
        if (obsCyc.size() > 0) begin
            nChecks++; if (obsCyc[0] != t + 2) begin nErrors++; $display("FAIL nonload_latency got %0d want %0d", obsCyc[0], t + 2); end
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front(); e = expQ.pop_front();
            nChecks++; if (o !== e) begin nErrors++; $display("FAIL nonload_wb got %h want %h", o, e); end
        end
        obsQ.delete(); obsCyc.delete(); expQ.delete();
    endtask

    task automatic test_extract();
        int r;
        wbT o, e;
        offer(M_LB, 32'h00001001, 32'h0, 5'd5);
        expQ.push_back({1'b1, 5'd5, 32'hFFFFFF80});
        respond(32'h00008000, r);
        tick();
        nChecks++; if (obsCyc.size() == 0 || obsCyc[0] != r + 2) begin nErrors++; $display("FAIL load_latency got %0d want %0d", (obsCyc.size() > 0) ? obsCyc[0] : -1, r + 2); end
        offer(M_LBU, 32'h00001001, 32'h0, 5'd6);
        expQ.push_back({1'b1, 5'd6, 32'h00000080});
        respond(32'h00008000, r);
        tick();
        // a[0] set on a halfword: upper half still selected by a[1].
        offer(M_LH, 32'h00000003, 32'h0, 5'd9);
        expQ.push_back({1'b1, 5'd9, 32'hFFFF8001});
        respond(32'h80010000, r);
        tick();
        offer(M_BAD, 32'h00000000, 32'h0, 5'd10);
        expQ.push_back({1'b0, 5'd10, 32'h0});
        respond(32'hFFFFFFFF, r);
        tick(); tick();
        nChecks++; if (obsQ.size() != 4) begin nErrors++; $display("FAIL extract_count got %0d want 4", obsQ.size()); end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front(); e = expQ.pop_front();
            nChecks++; if (o !== e) begin nErrors++; $display("FAIL extract_wb got %h want %h", o, e); end
        end
        obsQ.delete(); obsCyc.delete(); expQ.delete();
    endtask

    task automatic test_lwlr();
        int r;
        wbT o, e;
        offer(M_LWL, 32'h00000101, 32'hAABBCCDD, 5'd11);
`ifdef MYCPU_WB_LWLR_EN
        expQ.push_back({1'b1, 5'd11, 32'h3344CCDD});
`else
        expQ.push_back({1'b0, 5'd11, 32'h0});
`endif
        respond(32'h11223344, r);
        offer(M_LWR, 32'h00000102, 32'hAABBCCDD, 5'd12);
`ifdef MYCPU_WB_LWLR_EN
        expQ.push_back({1'b1, 5'd12, 32'hAABB1122});
`else
        expQ.push_back({1'b0, 5'd12, 32'h0});
`endif
        respond(32'h11223344, r);
        tick(); tick();
        nChecks++; if (obsQ.size() != 2) begin nErrors++; $display("FAIL lwlr_count got %0d want 2", obsQ.size()); end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front(); e = expQ.pop_front();
            nChecks++; if (o !== e) begin nErrors++; $display("FAIL lwlr_wb got %h want %h", o, e); end
        end
        obsQ.delete(); obsCyc.delete(); expQ.delete();
    endtask

    task automatic test_full_queue();
        int rc;
        wbT o, e;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_mode = M_LW; in_alu_result = 32'h100 + 32'(4 * i);
            in_dest = 5'(8 + i);
            expQ.push_back({1'b1, 5'(8 + i), 32'hA0000000 + 32'(i)});
            tick();
        end
        nChecks++; if (in_ready !== 1'b0) begin nErrors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        // Offer a non-load while full: it must be refused.
        rc = cyc;
        in_valid = 1'b1; in_mode = M_ALU; in_alu_result = 32'hDEAD; in_dest = 5'd1;
        rsp_valid = 1'b1; rsp_rdata = 32'hA0000000;
        tick();
        in_valid = 1'b0;
        nChecks++; if (in_ready !== 1'b0) begin nErrors++; $display("FAIL full_hold_ready got %b want 0", in_ready); end
        for (int i = 1; i < 4; i++) begin
            rsp_rdata = 32'hA0000000 + 32'(i);
            tick();
            if (i == 1) begin
                nChecks++; if (in_ready !== 1'b1) begin nErrors++; $display("FAIL full_reopen got %b want 1", in_ready); end
            end
        end
        rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        nChecks++; if (obsQ.size() != 4) begin nErrors++; $display("FAIL full_count got %0d want 4", obsQ.size()); end
        for (int i = 0; i < obsCyc.size(); i++) begin
            nChecks++; if (obsCyc[i] != rc + 2 + i) begin nErrors++; $display("FAIL full_cycle%0d got %0d want %0d", i, obsCyc[i], rc + 2 + i); end
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front(); e = expQ.pop_front();
            nChecks++; if (o !== e) begin nErrors++; $display("FAIL full_wb got %h want %h", o, e); end
        end
        obsQ.delete(); obsCyc.delete(); expQ.delete();
    endtask

    task automatic test_flush();
        int r;
        wbT o, e;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = M_LW; in_alu_result = 32'h200; in_dest = 5'(16 + i);
            tick();
        end
        in_valid = 1'b0;
        respond(32'h55555555, r);
        // Flush lands as the head load would retire; a new offer in the same cycle is dropped.
        flush = 1'b1; in_valid = 1'b1; in_mode = M_ALU; in_dest = 5'd2;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick(); tick();
        nChecks++; if (obsQ.size() != 0) begin nErrors++; $display("FAIL flush_no_wb got %0d want 0", obsQ.size()); end
        respond(32'h66666666, r);
        respond(32'h77777777, r);
        tick();
        nChecks++; if (rsp_err !== 1'b0) begin nErrors++; $display("FAIL flush_drop_err got %b want 0", rsp_err); end
        nChecks++; if (obsQ.size() != 0) begin nErrors++; $display("FAIL flush_drop_wb got %0d want 0", obsQ.size()); end
        offer(M_LW, 32'h300, 32'h0, 5'd7);
        expQ.push_back({1'b1, 5'd7, 32'hCAFEF00D});
        respond(32'hCAFEF00D, r);
        tick(); tick();
        nChecks++; if (obsQ.size() != 1) begin nErrors++; $display("FAIL flush_after_count got %0d want 1", obsQ.size()); end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front(); e = expQ.pop_front();
            nChecks++; if (o !== e) begin nErrors++; $display("FAIL flush_after_wb got %h want %h", o, e); end
        end
        nChecks++; if (rsp_err !== 1'b0) begin nErrors++; $display("FAIL flush_after_err got %b want 0", rsp_err); end
        obsQ.delete(); obsCyc.delete(); expQ.delete();
    endtask

    task automatic test_unexpected();
        int r;
        respond(32'h12121212, r);
        nChecks++; if (rsp_err !== 1'b1) begin nErrors++; $display("FAIL unexp_set got %b want 1", rsp_err); end
        tick(); tick(); tick();
        nChecks++; if (rsp_err !== 1'b1) begin nErrors++; $display("FAIL unexp_sticky got %b want 1", rsp_err); end
        // Asynchronous reset with a load pending, then its late response.
        offer(M_LW, 32'h400, 32'h0, 5'd13);
        @(negedge clk);
        reset = 1'b1;
        #1;
        nChecks++; if (rsp_err !== 1'b0) begin nErrors++; $display("FAIL async_rst_err got %b want 0", rsp_err); end
        nChecks++; if (in_ready !== 1'b1) begin nErrors++; $display("FAIL async_rst_ready got %b want 1", in_ready); end
        #2;
        reset = 1'b0;
        respond(32'h34343434, r);
        tick(); tick();
        nChecks++; if (rsp_err !== 1'b1) begin nErrors++; $display("FAIL late_rsp_err got %b want 1", rsp_err); end
        nChecks++; if (obsQ.size() != 0) begin nErrors++; $display("FAIL late_rsp_wb got %0d want 0", obsQ.size()); end
        obsQ.delete(); obsCyc.delete(); expQ.delete();
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_extract();
        test_lwlr();
        test_full_queue();
        test_flush();
        test_unexpected();
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
